// File: rtl/gate_selftest_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// gate_selftest_sequencer_pkg
// Shared definitions for the single-gate self-test controller and its golden
// reference model. It contains the gate type codes, the FSM state encoding,
// the last-vector indices, and a helper that reports whether a gate code is
// legal.
// -----------------------------------------------------------------------------
package gate_selftest_sequencer_pkg;

  // Gate type codes, as presented on gate_sel. Codes 6 and 7 are illegal.
  localparam logic [2:0] GATE_NOT  = 3'd0;
  localparam logic [2:0] GATE_AND  = 3'd1;
  localparam logic [2:0] GATE_OR   = 3'd2;
  localparam logic [2:0] GATE_NAND = 3'd3;
  localparam logic [2:0] GATE_NOR  = 3'd4;
  localparam logic [2:0] GATE_XOR  = 3'd5;

  // Index of the final vector in a run. NOT has 2 vectors; the others have 4.
  localparam logic [1:0] LAST_VEC_NOT = 2'd1;
  localparam logic [1:0] LAST_VEC_2IN = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_APPLY  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  function automatic logic is_legal_sel(input logic [2:0] sel);
    return (sel <= GATE_XOR);
  endfunction

endpackage

// File: rtl/gate_selftest_sequencer_golden_ref.sv
// -----------------------------------------------------------------------------
// gate_golden_ref
// Purely combinational reference model of the gate library. It returns the
// expected gate output for a gate type and the input pair (a, b). For NOT,
// only a is used. Illegal codes return 0.
//   sel  in  3  gate type code
//   a    in  1  gate input A
//   b    in  1  gate input B
//   y    out 1  expected gate output
// -----------------------------------------------------------------------------
module gate_golden_ref
  import gate_selftest_sequencer_pkg::*;
(
  input  logic [2:0] sel,
  input  logic       a,
  input  logic       b,
  output logic       y
);

  always_comb begin
    y = 1'b0;
    case (sel)
      GATE_NOT:  y = ~a;
      GATE_AND:  y = a & b;
      GATE_OR:   y = a | b;
      GATE_NAND: y = ~(a & b);
      GATE_NOR:  y = ~(a | b);
      GATE_XOR:  y = a ^ b;
      default:   y = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_selftest_sequencer.sv
// -----------------------------------------------------------------------------
// gate_selftest_sequencer
// Self-test controller for one external combinational gate. It walks every
// input vector for the selected gate type. For each vector it holds the
// stimulus for SETTLE_CYCLES, then samples dut_out and compares it against
// gate_golden_ref. At the end of the run it reports pass/fail, a saturating
// mismatch count, and the first vector that failed.
//   clk        in   1      rising-edge clock
//   reset      in   1      asynchronous, active-high
//   start      in   1      run request (sampled only in IDLE)
//   gate_sel   in   3      gate type, latched when a run is accepted
//   dut_out    in   1      output of the gate under test
//   stim_a     out  1      gate input A
//   stim_b     out  1      gate input B (held 0 for NOT)
//   busy       out  1      run in progress
//   done       out  1      one-cycle end-of-run pulse
//   pass       out  1      run clean and gate_sel legal; held until next start
//   sel_err    out  1      run aborted on illegal gate_sel; held like pass
//   err_count  out  ERR_W  saturating mismatch count
//   fail_vec   out  2      {a,b} of first mismatch, valid when err_count != 0
//   dbg_state  out  3      current FSM state (state_e encoding)
//
// Handshake: start is a level request. A run is accepted on any rising edge
// where the FSM is in IDLE and start is 1; start is ignored in every other
// state. Each accepted run ends with exactly one done pulse, unless reset
// aborts it. If start stays high, a new run is accepted after a single IDLE
// cycle.
// -----------------------------------------------------------------------------
module gate_selftest_sequencer
  import gate_selftest_sequencer_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       gate_sel,
  input  logic             dut_out,
  output logic             stim_a,
  output logic             stim_b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             sel_err,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       fail_vec,
  output logic [2:0]       dbg_state
);

  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  state_e           state_q, state_d;
  logic [2:0]       sel_q, sel_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             stim_a_q, stim_a_d;
  logic             stim_b_q, stim_b_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [1:0]       fail_vec_q, fail_vec_d;
  logic             pass_q, pass_d;
  logic             sel_err_q, sel_err_d;

  logic golden_y;
  logic mismatch;
  logic last_vec;

  // The golden model checks the stimulus that is currently driven, so it
  // matches exactly what the gate under test sees during CHECK.
  gate_golden_ref u_golden (
    .sel (sel_q),
    .a   (stim_a_q),
    .b   (stim_b_q),
    .y   (golden_y)
  );

  assign mismatch = (dut_out != golden_y);
  assign last_vec = (sel_q == GATE_NOT) ? (idx_q == LAST_VEC_NOT)
                                        : (idx_q == LAST_VEC_2IN);

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    stim_a_d   = stim_a_q;
    stim_b_d   = stim_b_q;
    err_d      = err_q;
    fail_vec_d = fail_vec_q;
    pass_d     = pass_q;
    sel_err_d  = sel_err_q;

    case (state_q)
      ST_IDLE: begin
        stim_a_d = 1'b0;
        stim_b_d = 1'b0;
        if (start) begin
          sel_d      = gate_sel;
          idx_d      = 2'd0;
          err_d      = '0;
          fail_vec_d = 2'b00;
          pass_d     = 1'b0;
          sel_err_d  = 1'b0;
          if (is_legal_sel(gate_sel)) begin
            state_d = ST_APPLY;
          end else begin
            // Abort straight to DONE. The verdict is ready when done rises.
            sel_err_d = 1'b1;
            state_d   = ST_DONE;
          end
        end
      end

      ST_APPLY: begin
        // The stimulus is registered, so the new vector appears on the
        // edge that leaves APPLY.
        if (sel_q == GATE_NOT) begin
          stim_a_d = idx_q[0];
          stim_b_d = 1'b0;
        end else begin
          stim_a_d = idx_q[1];
          stim_b_d = idx_q[0];
        end
        cnt_d   = 4'(SETTLE_CYCLES);
        state_d = ST_SETTLE;
      end

      ST_SETTLE: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = ST_CHECK;
        end
      end

      ST_CHECK: begin
        if (mismatch) begin
          if (err_q != ERR_MAX) begin
            err_d = err_q + ERR_W'(1);
          end
          if (err_q == '0) begin
            fail_vec_d = {stim_a_q, stim_b_q};
          end
        end
        if (last_vec) begin
          // err_q does not yet include this vector, so the last compare
          // is folded in here.
          pass_d   = (err_q == '0) && !mismatch;
          stim_a_d = 1'b0;
          stim_b_d = 1'b0;
          state_d  = ST_DONE;
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = ST_APPLY;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      sel_q      <= 3'd0;
      idx_q      <= 2'd0;
      cnt_q      <= 4'd0;
      stim_a_q   <= 1'b0;
      stim_b_q   <= 1'b0;
      err_q      <= '0;
      fail_vec_q <= 2'b00;
      pass_q     <= 1'b0;
      sel_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      stim_a_q   <= stim_a_d;
      stim_b_q   <= stim_b_d;
      err_q      <= err_d;
      fail_vec_q <= fail_vec_d;
      pass_q     <= pass_d;
      sel_err_q  <= sel_err_d;
    end
  end

  assign stim_a    = stim_a_q;
  assign stim_b    = stim_b_q;
  assign busy      = (state_q == ST_APPLY) || (state_q == ST_SETTLE) ||
                     (state_q == ST_CHECK);
  assign done      = (state_q == ST_DONE);
  assign pass      = pass_q;
  assign sel_err   = sel_err_q;
  assign err_count = err_q;
  assign fail_vec  = fail_vec_q;
  assign dbg_state = state_q;

endmodule
